// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer, the sequential BCD converter and its consumer.
// The slave modport is the converter side; the master modport is the producer/consumer side.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    localparam int NDW = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign;
    logic [NDW-1:0]        ndigits;

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, sign, ndigits
    );

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, sign, ndigits
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with
// optional sign-magnitude handling, significant-digit count and valid/ready on both sides.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int AW  = 4 * DIGITS;
    localparam int CW  = $clog2(BIN_W + 1);
    localparam int NDW = $clog2(DIGITS + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    generate
        if (BIN_W < 2 || BIN_W > 32) begin : g_bad_width
            $error("bin2bcd_seq: BIN_W must be in 2..32");
        end
        if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  shreg_q, shreg_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [AW-1:0]     bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic [NDW-1:0]    nd_q, nd_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic              neg_in;
    logic [BIN_W-1:0]  mag;
    logic [AW-1:0]     acc_corr;
    logic [AW+BIN_W-1:0] shifted;
    logic [AW-1:0]     acc_shift;
    logic [BIN_W-1:0]  sh_shift;
    logic [NDW-1:0]    nd_calc;

    // Negation wraps in BIN_W bits so the most negative input yields 2^(BIN_W-1) exactly.
    assign neg_in = SIGNED && bus.bin[BIN_W-1];
    assign mag    = neg_in ? (~bus.bin + BIN_W'(1)) : bus.bin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_corr
            assign acc_corr[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                         acc_q[4*gi +: 4] + 4'd3 : acc_q[4*gi +: 4];
        end
    endgenerate

    assign shifted   = {acc_corr, shreg_q} << 1;
    assign acc_shift = shifted[AW+BIN_W-1:BIN_W];
    assign sh_shift  = shifted[BIN_W-1:0];

    always_comb begin
        nd_calc = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_shift[4*i +: 4] != 4'd0) nd_calc = NDW'(i + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            nd_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            nd_q        <= nd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        nd_d    = nd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    shreg_d = mag;
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = neg_in;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = acc_shift;
                shreg_d = sh_shift;
                cnt_d   = cnt_q + CW'(1);
                // Result registers load on the last shift so they are valid with out_valid.
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d = DONE;
                    bcd_d   = acc_shift;
                    nd_d    = nd_calc;
                    sign_d  = neg_q;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
    assign bus.sign      = sign_q;
    assign bus.ndigits   = nd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: 16-bit unsigned, 8-bit unsigned and 8-bit signed instances.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if_a ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if_b ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if_c ();

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        int          w;
        logic [19:0] bcd;
        logic        sign;
        int          nd;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   seen[3];

    function automatic int binw(int w);
        return (w == 0) ? 16 : 8;
    endfunction

    function automatic logic g_ov(int w);
        case (w) 0: return if_a.out_valid; 1: return if_b.out_valid; default: return if_c.out_valid; endcase
    endfunction
    function automatic logic g_ir(int w);
        case (w) 0: return if_a.in_ready; 1: return if_b.in_ready; default: return if_c.in_ready; endcase
    endfunction
    function automatic logic g_ordy(int w);
        case (w) 0: return if_a.out_ready; 1: return if_b.out_ready; default: return if_c.out_ready; endcase
    endfunction
    function automatic logic g_sign(int w);
        case (w) 0: return if_a.sign; 1: return if_b.sign; default: return if_c.sign; endcase
    endfunction
    function automatic logic [19:0] g_bcd(int w);
        case (w) 0: return if_a.bcd; 1: return {8'h0, if_b.bcd}; default: return {8'h0, if_c.bcd}; endcase
    endfunction
    function automatic int g_nd(int w);
        case (w) 0: return int'(if_a.ndigits); 1: return int'(if_b.ndigits); default: return int'(if_c.ndigits); endcase
    endfunction

    task automatic drive(int w, logic v, logic [15:0] b);
        case (w)
            0: begin if_a.in_valid = v; if_a.bin = b; end
            1: begin if_b.in_valid = v; if_b.bin = b[7:0]; end
            default: begin if_c.in_valid = v; if_c.bin = b[7:0]; end
        endcase
    endtask

    task automatic set_ordy(int w, logic r);
        case (w) 0: if_a.out_ready = r; 1: if_b.out_ready = r; default: if_c.out_ready = r; endcase
    endtask

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name, string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Decimal reference built by repeated division, independent of shift-and-add.
    function automatic logic [19:0] dec(int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ndig(logic [19:0] d);
        int n;
        n = 1;
        for (int i = 0; i < 5; i++) if (d[4*i +: 4] != 4'd0) n = i + 1;
        return n;
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(int w, logic [15:0] b, logic [19:0] eb, logic es, int en, bit hold);
        int   n;
        exp_t e;
        n = 0;
        drive(w, 1'b1, b);
        @(negedge clk);
        while (!g_ir(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!g_ir(w)) begin
            fail("accept_timeout", $sformatf("unit %0d bin %0h never accepted", w, b));
        end else begin
            e.w = w; e.bcd = eb; e.sign = es; e.nd = en; e.acc_cyc = cyc + 1;
            sb.push_back(e);
            last_acc = cyc + 1;
            $display("send unit=%0d bin=%0h expect bcd=%0h sign=%0b nd=%0d", w, b, eb, es, en);
        end
        @(posedge clk);
        #1;
        if (!hold) drive(w, 1'b0, 16'($urandom));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) fail("drain_timeout", $sformatf("%0d results never presented", sb.size()));
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_in_ready"},  g_ir(0), 0);
        chk({tag, "_out_valid"}, g_ov(0), 0);
        chk({tag, "_bcd"},       g_bcd(0), 0);
        chk({tag, "_sign"},      g_sign(0), 0);
        chk({tag, "_ndigits"},   g_nd(0), 0);
    endtask

    // Monitor: latency on out_valid rise, full compare on each output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = '{0, 0, 0};
            end else begin
                for (int w = 0; w < 3; w++) begin
                    if (g_ov(w) && !seen[w]) begin
                        seen[w] = 1;
                        if (sb.size() == 0 || sb[0].w != w)
                            fail("unexpected_output", $sformatf("unit %0d bcd %0h with no pending request", w, g_bcd(w)));
                        else
                            chk("latency", cyc - sb[0].acc_cyc, binw(w));
                    end
                    if (g_ov(w) && g_ordy(w)) begin
                        seen[w] = 0;
                        if (sb.size() != 0 && sb[0].w == w) begin
                            mon_e = sb.pop_front();
                            $display("recv unit=%0d bcd=%0h sign=%0b nd=%0d", w, g_bcd(w), g_sign(w), g_nd(w));
                            chk("bcd", g_bcd(w), mon_e.bcd);
                            chk("sign", g_sign(w), mon_e.sign);
                            chk("ndigits", g_nd(w), mon_e.nd);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int a1;
        int hits;
        logic [19:0] d;
        for (int w = 0; w < 3; w++) begin
            drive(w, 1'b0, 16'h0);
            set_ordy(w, 1'b1);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_before_edge", g_ir(0), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", g_ir(0), 1);

        send(0, 16'd65535, 20'h65535, 1'b0, 5, 0);
        send(0, 16'd0,     20'h00000, 1'b0, 1, 0);
        wait_idle();

        for (int v = 0; v < 256; v++) begin
            d = dec(v);
            send(1, 16'(v), d, 1'b0, ndig(d), 0);
        end
        wait_idle();

        send(2, 16'h80, 20'h128, 1'b1, 3, 0);
        send(2, 16'hFF, 20'h001, 1'b1, 1, 0);
        send(2, 16'h7F, 20'h127, 1'b0, 3, 0);
        send(2, 16'h9C, 20'h100, 1'b1, 3, 0);
        send(2, 16'h00, 20'h000, 1'b0, 1, 0);
        wait_idle();

        // Backpressure: result must hold while out_ready is low.
        set_ordy(0, 1'b0);
        send(0, 16'd1234, 20'h01234, 1'b0, 4, 0);
        hits = 0;
        while (!g_ov(0) && hits < 40) begin
            @(negedge clk);
            hits++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", g_ov(0), 1);
            chk("bp_bcd", g_bcd(0), 20'h01234);
            chk("bp_ndigits", g_nd(0), 4);
            chk("bp_in_ready", g_ir(0), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 set_ordy(0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", g_ir(0), 1);
        chk("post_hs_out_valid", g_ov(0), 0);
        chk("post_hs_bcd_held", g_bcd(0), 20'h01234);
        @(posedge clk);
        #1;
        wait_idle();

        // Back-to-back with in_valid held; bin changes to 42 while 9999 converts.
        send(0, 16'd9999, 20'h09999, 1'b0, 4, 1);
        a1 = last_acc;
        send(0, 16'd42, 20'h00042, 1'b0, 2, 0);
        chk("accept_spacing", last_acc - a1, 18);
        wait_idle();

        // Reset abort in the middle of a conversion.
        send(0, 16'd50000, 20'h50000, 1'b0, 5, 0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_reset_vals("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (g_ov(0)) hits++;
        end
        chk("aborted_out_valid_count", hits, 0);
        @(posedge clk);
        #1;
        send(0, 16'd321, 20'h00321, 1'b0, 3, 0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one input bit per clock.
- Generalises the combinational 8-bit converter to any input width and digit count.
- Adds an optional two's-complement signed mode, a significant-digit count for display blanking, and valid/ready handshakes on both sides.
- Sits between the binary datapath (counters, price/quantity fields) and display/ASCII formatting logic.

Parameters:
BIN_W, 16, input binary width in bits (2..32).
DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; violation is an elaboration-time error.
SIGNED, 0, 0 = input unsigned; 1 = input two's complement, output is sign + magnitude.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept a word
bin  in  BIN_W  binary input, sampled only on accept
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in [3:0]
sign  out  1  1 = negative input (SIGNED=1 only; tied 0 when SIGNED=0)
ndigits  out  clog2(DIGITS+1)  count of significant digits, 1..DIGITS

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high: state=IDLE, in_ready=0, out_valid=0, bcd=0, sign=0, ndigits=0, internal shift and count registers 0. in_ready goes to 1 on the first clk edge after rst deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load the shift register with the magnitude of bin, clear the BCD accumulator, clear the bit counter, capture sign, go to SHIFT.
  - Magnitude: SIGNED=0 → bin as is. SIGNED=1 and bin[BIN_W-1]=1 → (~bin+1) treated as BIN_W-bit unsigned, so the most negative value -2^(BIN_W-1) gives magnitude 2^(BIN_W-1) exactly. Otherwise → bin.
- SHIFT:
  - in_ready=0. Once per cycle:
    1. Every accumulator digit >=5 gets +3 (4-bit, no carry between digits).
    2. The whole {accumulator, shift register} is shifted left 1, with the shift-register MSB entering accumulator bit 0.
    3. The counter increments.
  - After exactly BIN_W SHIFT cycles: go to DONE, drive bcd from the accumulator, compute ndigits, set out_valid=1.
  - Correction before the shift on every iteration, including the first (which is a no-op), is the required ordering; no correction after the final shift.
- DONE:
  - out_valid=1; bcd, sign and ndigits are held stable until the handshake.
  - On out_ready: next edge goes to IDLE and out_valid=0. bcd, sign and ndigits keep their last values (not cleared).
- Latency: accept edge N → out_valid high after edge N+BIN_W. Minimum period between accepts is BIN_W+2 cycles with out_ready tied high.
- ndigits: 1 + index of the highest non-zero digit; value 0 gives ndigits=1.
- bin and in_valid are ignored outside IDLE; bin changes during a conversion have no effect.
- out_ready is ignored outside DONE.
- rst asserted mid-SHIFT or in DONE aborts immediately to the reset values; the partial result is discarded and never presented.
- No overflow is possible given the DIGITS constraint; unused high digits are 0.

Test Plan:
- BIN_W=16, DIGITS=5, SIGNED=0, out_ready=1; send 65535 → out_valid exactly 16 cycles after the accept edge, bcd=0x65535, ndigits=5. Then send 0 → bcd=0x00000, ndigits=1.
- BIN_W=8, DIGITS=3: sweep all values 0..255 → bcd matches the legacy combinational 8-bit converter for every value (e.g. 255→0x255, 9→0x009 with ndigits=1).
- SIGNED=1, BIN_W=8, DIGITS=3: 0x80 → sign=1, bcd=0x128. 0xFF → sign=1, bcd=0x001. 0x7F → sign=0, bcd=0x127.
- Backpressure: complete 1234, hold out_ready=0 for 10 cycles → out_valid, bcd=0x01234 and ndigits=4 stable throughout, in_ready=0. Raise out_ready → one-cycle handshake, in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with 9999 then 42, out_ready=1 → results 0x09999 then 0x00042 in order, accepts spaced 18 cycles apart (BIN_W=16). Changing bin mid-conversion does not corrupt the result.
- Assert rst for 1 cycle at SHIFT cycle 7 of a 50000 conversion → out_valid never asserts for it, all outputs return to reset values, and the next conversion of 321 gives 0x00321.
